// File: rtl/microwave_pkg.sv
// rtl/microwave_pkg.sv - shared types, 7-segment table and keypad helpers for the oven controller
package microwave_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COOK   = 2'd1,
        PAUSED = 2'd2
    } state_e;

    // Active-high segments, bit0 = a .. bit6 = g.
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    function automatic logic kbd_is_onehot(input logic [9:0] kbd);
        return (kbd != 10'd0) && ((kbd & (kbd - 10'd1)) == 10'd0);
    endfunction

    function automatic logic [3:0] kbd_to_digit(input logic [9:0] kbd);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (kbd[i]) d = 4'(i);
        end
        return d;
    endfunction

endpackage

// File: rtl/microwave_if.sv
// rtl/microwave_if.sv - oven front-panel pins: keypad, buttons, door switch, displays, magnetron
interface microwave_if;
    logic [9:0] kbd;
    logic       startn;
    logic       stopn;
    logic       clearn;
    logic       door_closed;
    logic [6:0] sec_ones_seg;
    logic [6:0] sec_tens_seg;
    logic [6:0] min_segs;
    logic       mag_on;

    modport master (
        output kbd, startn, stopn, clearn, door_closed,
        input  sec_ones_seg, sec_tens_seg, min_segs, mag_on
    );

    modport slave (
        input  kbd, startn, stopn, clearn, door_closed,
        output sec_ones_seg, sec_tens_seg, min_segs, mag_on
    );
endinterface

// File: rtl/microwave_bcd_to_7seg.sv
// rtl/microwave_bcd_to_7seg.sv - BCD digit to active-high 7-segment decode; codes 10-15 blank
module bcd_to_7seg
    import microwave_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h00;
        for (int i = 0; i < 10; i++) begin
            if (bcd_i == 4'(i)) seg_o = SEG_TABLE[i];
        end
    end

endmodule

// File: rtl/microwave.sv
// rtl/microwave.sv - oven controller: keypad time entry, cook/pause FSM, BCD countdown, displays
module microwave
    import microwave_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic        clk,
    input  logic        rst,
    microwave_if.slave  bus
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    state_e        state_q, state_d;
    logic [3:0]    m_q, m_d, s1_q, s1_d, s0_q, s0_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          key_prev_q, key_prev_d;
    logic          mag_q, mag_d;

    logic key_any, key_rise, time_zero, start_ok;

    assign key_any   = |bus.kbd;
    assign key_rise  = key_any && !key_prev_q;
    assign time_zero = (m_q == 4'd0) && (s1_q == 4'd0) && (s0_q == 4'd0);
    // Stop and an open door both outrank start.
    assign start_ok  = !bus.startn && bus.stopn && bus.door_closed && !time_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            m_q        <= 4'd0;
            s1_q       <= 4'd0;
            s0_q       <= 4'd0;
            presc_q    <= '0;
            key_prev_q <= 1'b0;
            mag_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            s1_q       <= s1_d;
            s0_q       <= s0_d;
            presc_q    <= presc_d;
            key_prev_q <= key_prev_d;
            mag_q      <= mag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        s1_d       = s1_q;
        s0_d       = s0_q;
        presc_d    = presc_q;
        key_prev_d = key_any;

        if (!bus.clearn) begin
            state_d = IDLE;
            m_d     = 4'd0;
            s1_d    = 4'd0;
            s0_d    = 4'd0;
            presc_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_d = COOK;
                        presc_d = '0;
                    end else if (key_rise && kbd_is_onehot(bus.kbd)) begin
                        m_d  = s1_q;
                        s1_d = s0_q;
                        s0_d = kbd_to_digit(bus.kbd);
                    end
                end
                COOK: begin
                    if (!bus.stopn || !bus.door_closed) begin
                        state_d = PAUSED;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        if (s0_q != 4'd0) begin
                            s0_d = s0_q - 4'd1;
                        end else if (s1_q != 4'd0) begin
                            s0_d = 4'd9;
                            s1_d = s1_q - 4'd1;
                        end else begin
                            s0_d = 4'd9;
                            s1_d = 4'd5;
                            m_d  = m_q - 4'd1;
                        end
                        // Finishing drops to IDLE on the same edge the display reaches 0:00.
                        if (m_d == 4'd0 && s1_d == 4'd0 && s0_d == 4'd0) state_d = IDLE;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSED: begin
                    if (start_ok) begin
                        state_d = COOK;
                        presc_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        mag_d = (state_d == COOK);
    end

    assign bus.mag_on = mag_q;

    bcd_to_7seg u_seg_ones (.bcd_i(s0_q), .seg_o(bus.sec_ones_seg));
    bcd_to_7seg u_seg_tens (.bcd_i(s1_q), .seg_o(bus.sec_tens_seg));
    bcd_to_7seg u_seg_min  (.bcd_i(m_q),  .seg_o(bus.min_segs));

endmodule

// File: tb/tb_microwave.sv
// tb/tb_microwave.sv - directed self-checking bench for the oven controller
module tb_microwave;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    microwave_if bus ();

    microwave #(.TICKS_PER_SEC(100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int m, input int s1, input int s0, input logic mag);
        logic [21:0] obs, exp;
        obs = {bus.min_segs, bus.sec_tens_seg, bus.sec_ones_seg, bus.mag_on};
        exp = {seg(m), seg(s1), seg(s0), mag};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic press(input int d);
        bus.kbd = 10'd1 << d;
        ticks(1);
        bus.kbd = 10'd0;
        ticks(1);
    endtask

    task automatic start_btn();
        bus.startn = 1'b0;
        ticks(1);
        bus.startn = 1'b1;
    endtask

    task automatic clear_btn();
        bus.clearn = 1'b0;
        ticks(1);
        bus.clearn = 1'b1;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.kbd       = 10'd0;
        bus.startn    = 1'b1;
        bus.stopn     = 1'b1;
        bus.clearn    = 1'b1;
        bus.door_closed = 1'b1;
        #23;
        check("reset", 0, 0, 0, 1'b0);
        rst = 1'b0;
        ticks(1);
        clear_btn();
        check("clear_after_reset", 0, 0, 0, 1'b0);

        start_btn();
        check("start_at_zero_ignored", 0, 0, 0, 1'b0);

        press(1); press(2);
        check("entry_12", 0, 1, 2, 1'b0);
        start_btn();
        check("cook_12_start", 0, 1, 2, 1'b1);
        ticks(100);
        check("cook_12_1s", 0, 1, 1, 1'b1);
        ticks(1099);
        check("cook_12_last_cycle", 0, 0, 1, 1'b1);
        ticks(1);
        check("cook_12_done", 0, 0, 0, 1'b0);

        press(3); press(5);
        check("entry_35", 0, 3, 5, 1'b0);
        start_btn();
        ticks(500);
        check("cook_35_5s", 0, 3, 0, 1'b1);
        bus.stopn = 1'b0;
        ticks(1);
        bus.stopn = 1'b1;
        check("stop_paused", 0, 3, 0, 1'b0);
        ticks(200);
        check("stop_held", 0, 3, 0, 1'b0);
        clear_btn();
        check("clear_from_pause", 0, 0, 0, 1'b0);

        press(1); press(2); press(9);
        check("entry_129", 1, 2, 9, 1'b0);
        start_btn();
        ticks(300);
        check("cook_129_3s", 1, 2, 6, 1'b1);
        bus.door_closed = 1'b0;
        ticks(1);
        check("door_open_pause", 1, 2, 6, 1'b0);
        start_btn();
        check("start_door_open_ignored", 1, 2, 6, 1'b0);
        bus.door_closed = 1'b1;
        ticks(50);
        check("door_closed_no_resume", 1, 2, 6, 1'b0);
        start_btn();
        check("resume", 1, 2, 6, 1'b1);
        ticks(300);
        check("resume_3s", 1, 2, 3, 1'b1);
        clear_btn();
        check("clear_from_cook", 0, 0, 0, 1'b0);

        press(7); press(2);
        start_btn();
        check("cook_72_start", 0, 7, 2, 1'b1);
        ticks(300);
        check("cook_72_3s", 0, 6, 9, 1'b1);
        clear_btn();

        bus.kbd = 10'b0000000011;
        ticks(1);
        bus.kbd = 10'd0;
        ticks(1);
        check("non_onehot_ignored", 0, 0, 0, 1'b0);
        press(1); press(2); press(3); press(4);
        check("oldest_digit_dropped", 2, 3, 4, 1'b0);
        clear_btn();

        press(8); press(0);
        start_btn();
        check("cook_80_start", 0, 8, 0, 1'b1);
        ticks(100);
        check("cook_80_1s", 0, 7, 9, 1'b1);
        clear_btn();

        press(1); press(0); press(0);
        check("entry_100", 1, 0, 0, 1'b0);
        start_btn();
        ticks(100);
        check("minute_borrow", 0, 5, 9, 1'b1);
        ticks(50);
        rst = 1'b1;
        #1;
        check("async_reset_mid_cook", 0, 0, 0, 1'b0);
        ticks(1);
        rst = 1'b0;
        ticks(2);
        check("after_reset_release", 0, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
